// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared constants, state encoding and small helpers for the
//               RV32M iterative multiply/divide unit.
//               - MD_OP_*          funct3 encodings of the eight M-extension ops
//               - MD_FUNCT7        funct7 that steers R-type ops to this unit
//               - MD_OPCODE_OP     R-type major opcode (for the decoder)
//               - md_state_e       FSM encoding (IDLE/BUSY/DONE)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    // Decoder uses these to route an R-type instruction here instead of the ALU.
    localparam logic [6:0] MD_FUNCT7    = 7'b0000001;
    localparam logic [6:0] MD_OPCODE_OP = 7'b0110011;

    typedef enum logic [1:0] {
        MD_STATE_IDLE = 2'b00,
        MD_STATE_BUSY = 2'b01,
        MD_STATE_DONE = 2'b10
    } md_state_e;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_signfix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_signfix
// Description : Combinational sign correction and result selection.
//               The iterative core works on magnitudes; this block restores
//               the sign of the product/quotient/remainder and picks the
//               32-bit writeback word for the op.
// Ports       : op        - funct3 of the op in flight
//               a_neg     - rs1 was negative and treated as signed
//               b_neg     - rs2 was negative and treated as signed
//               product   - unsigned magnitude product (2*XLEN bits)
//               quotient  - unsigned magnitude quotient
//               remainder - unsigned magnitude remainder
//               result    - corrected writeback value
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic              a_neg,
    input  logic              b_neg,
    input  logic [2*XLEN-1:0] product,
    input  logic [XLEN-1:0]   quotient,
    input  logic [XLEN-1:0]   remainder,
    output logic [XLEN-1:0]   result
);

    logic              w_neg_res;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // Product and quotient are negative when the operand signs differ;
    // the remainder follows the dividend.
    assign w_neg_res  = a_neg ^ b_neg;
    assign w_prod_fix = w_neg_res ? -product  : product;
    assign w_quo_fix  = w_neg_res ? -quotient : quotient;
    assign w_rem_fix  = a_neg     ? -remainder : remainder;

    always_comb begin
        result = '0;
        case (op)
            MD_OP_MUL:                            result = w_prod_fix[XLEN-1:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: result = w_prod_fix[2*XLEN-1:XLEN];
            MD_OP_DIV, MD_OP_DIVU:                result = w_quo_fix;
            default:                              result = w_rem_fix;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Radix-2 shift-add multiply and restoring divide, one bit per
//               cycle, with valid/ready handshakes on both sides.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               in_valid   - EX presents an M-op       in_ready  - IDLE only
//               op         - funct3                    rs1, rs2  - operands
//               kill       - flush, aborts any op
//               out_valid  - result valid              out_ready - consumer
//               result     - writeback value, stable while stalled
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        r_state;
    md_state_e        w_state_nxt;

    logic [2:0]       r_op;
    logic             r_a_neg;
    logic             r_b_neg;
    logic [XLEN-1:0]  r_hi;     // multiply accumulator / partial remainder
    logic [XLEN-1:0]  r_lo;     // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]  r_b;      // multiplicand / divisor magnitude
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;

    // ---------------- operand decode at accept ----------------
    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_result;

    assign w_accept = (r_state == MD_STATE_IDLE) && in_valid && !kill;
    assign w_a_neg  = md_a_signed(op) & rs1[XLEN-1];
    assign w_b_neg  = md_b_signed(op) & rs2[XLEN-1];
    assign w_mag_a  = w_a_neg ? -rs1 : rs1;
    assign w_mag_b  = w_b_neg ? -rs2 : rs2;

    // Divide by zero and signed overflow have architecturally fixed results,
    // so they skip the iterative loop entirely.
    assign w_div_zero = op[2] && (rs2 == '0);
    assign w_div_ovf  = ((op == MD_OP_DIV) || (op == MD_OP_REM)) &&
                        (rs1 == c_min_neg) && (rs2 == '1);
    assign w_fast     = w_div_zero || w_div_ovf;

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = op[1] ? rs1 : '1;           // REM* : DIV*
        end else if (w_div_ovf) begin
            w_fast_result = op[1] ? '0 : c_min_neg;
        end
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_mul_hi;
    logic [XLEN-1:0] w_mul_lo;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_div_hi;
    logic [XLEN-1:0] w_div_lo;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic [XLEN-1:0] w_iter_result;

    // Multiply: the carry out of the add becomes the new MSB of the
    // accumulator after the right shift, and the accumulator LSB moves
    // into the vacated top of the multiplier register.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi = w_sum[XLEN:1];
    assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};

    // Divide: partial remainder is always below the divisor, so after the
    // shift the difference fits in XLEN bits whenever it is taken.
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_hi = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
    assign w_div_lo = {r_lo[XLEN-2:0], w_ge};

    assign w_hi_nxt = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_lo_nxt = r_op[2] ? w_div_lo : w_mul_lo;

    // The final iteration's values feed the sign fix directly so the result
    // is captured on the same edge that enters DONE.
    muldiv_signfix #(
        .XLEN (XLEN)
    ) u_signfix (
        .op        (r_op),
        .a_neg     (r_a_neg),
        .b_neg     (r_b_neg),
        .product   ({w_hi_nxt, w_lo_nxt}),
        .quotient  (w_lo_nxt),
        .remainder (w_hi_nxt),
        .result    (w_iter_result)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_STATE_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = MD_STATE_IDLE;
        end else begin
            case (r_state)
                MD_STATE_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = w_fast ? MD_STATE_DONE : MD_STATE_BUSY;
                    end
                end
                MD_STATE_BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = MD_STATE_DONE;
                    end
                end
                MD_STATE_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = MD_STATE_IDLE;
                    end
                end
                default: w_state_nxt = MD_STATE_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
            r_cnt   <= CNT_W'(XLEN);
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if ((r_state == MD_STATE_BUSY) && !kill) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_result <= w_iter_result;
            end
        end
    end

    assign in_ready  = (r_state == MD_STATE_IDLE);
    assign out_valid = (r_state == MD_STATE_DONE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed vector table,
//               hand-written kill/reset/backpressure sequences and random ops
//               checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MD_OP_MUL:    begin p = sa * sb; return p[31:0];  end
            MD_OP_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_OP_DIV:    begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb;
                return p[31:0];
            end
            MD_OP_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            MD_OP_REM:    begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default:      return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == MD_OP_DIV || o == MD_OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return 1;
        return 33;
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        step();
        in_valid = 1'b0;
        op       = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    // Returns cycles from accept edge until out_valid is seen (1 = next cycle).
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int stall,
                         input string nm);
        int          n;
        logic [31:0] held;
        check({nm, " in_ready"}, 64'(in_ready), 64'(1));
        start_op(o, a, b);
        wait_valid(n);
        check({nm, " latency"}, 64'(n), 64'(lat));
        check({nm, " result"}, 64'(result), 64'(exp));
        held = result;
        for (int i = 0; i < stall; i++) begin
            step();
            check({nm, " stall"}, {61'b0, out_valid, in_ready, result == held}, 64'b101);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, " release"}, {62'b0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        int          n;
        int          seen;
        logic [2:0]  o;
        logic [31:0] a, b;

        rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        kill = 1'b0; out_ready = 1'b0;

        vecs[0]  = '{MD_OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3"};
        vecs[1]  = '{MD_OP_MULH,   32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 33, "mulh_7_m3"};
        vecs[2]  = '{MD_OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"};
        vecs[3]  = '{MD_OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33, "div_m7_2"};
        vecs[4]  = '{MD_OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33, "rem_m7_2"};
        vecs[5]  = '{MD_OP_DIVU,   32'd100,        32'd7,        32'd14,       33, "divu_100_7"};
        vecs[6]  = '{MD_OP_REMU,   32'd100,        32'd7,        32'd2,        33, "remu_100_7"};
        vecs[7]  = '{MD_OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1,  "divu_by0"};
        vecs[8]  = '{MD_OP_REM,    32'd5,          32'd0,        32'd5,        1,  "rem_by0"};
        vecs[9]  = '{MD_OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"};
        vecs[10] = '{MD_OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1,  "rem_ovf"};
        vecs[11] = '{MD_OP_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'd0,        33, "divu_nonovf"};
        vecs[12] = '{MD_OP_DIV,    32'h80000000,   32'd0,        32'hFFFFFFFF, 1,  "div_by0"};
        vecs[13] = '{MD_OP_MULHSU, 32'hFFFFFFFE,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhsu_m2"};

        repeat (3) step();
        rst = 1'b0;
        check("reset state", {31'b0, in_ready, out_valid, result}, {31'b0, 1'b1, 1'b0, 32'h0});

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                  (i % 3 == 0) ? 1 : 0, vecs[i].name);
        end

        // Backpressure: five stalled cycles in DONE
        do_op(MD_OP_MUL, 32'd1234, 32'd5678, 32'd7006652, 33, 5, "backpressure");

        // Kill on the 10th BUSY iteration, then a normal op
        start_op(MD_OP_MUL, 32'd99, 32'd77);
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill busy -> idle", {62'b0, out_valid, in_ready}, 64'b01);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("kill busy no valid", 64'(seen), 64'(0));
        do_op(MD_OP_MULHSU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "after_kill");

        // Kill while DONE with out_ready high: kill wins
        start_op(MD_OP_DIVU, 32'd9, 32'd0);
        out_ready = 1'b1;
        kill = 1'b1;
        step();
        kill = 1'b0;
        out_ready = 1'b0;
        check("kill done", {62'b0, out_valid, in_ready}, 64'b01);

        // Reset mid-BUSY
        start_op(MD_OP_DIVU, 32'd1000, 32'd3);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", {31'b0, in_ready, out_valid, result}, {31'b0, 1'b1, 1'b0, 32'h0});

        // Reset while DONE holding a nonzero result
        start_op(MD_OP_DIVU, 32'd1000, 32'd3);
        wait_valid(n);
        check("pre-rst done result", 64'(result), 64'(333));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst done", {31'b0, in_ready, out_valid, result}, {31'b0, 1'b1, 1'b0, 32'h0});

        // kill + in_valid together in IDLE: a fast-path op must not be accepted
        in_valid = 1'b1; op = MD_OP_DIVU; rs1 = 32'd5; rs2 = 32'd0; kill = 1'b1;
        step();
        in_valid = 1'b0; kill = 1'b0;
        check("kill+in_valid idle", {62'b0, out_valid, in_ready}, 64'b01);
        step();
        check("kill+in_valid no valid", 64'(out_valid), 64'(0));

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(o, a, b, model(o, a, b), model_lat(o, a, b),
                  $urandom_range(0, 2), $sformatf("rand%0d op%0d", i, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Shares the same operand buses (rs1/rs2 values after forwarding) and returns a 32-bit writeback result.
- Uses a valid/ready handshake so the pipeline stalls while an M-extension op is in flight.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- CNT_W, 6, iteration counter width (holds 0..32).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX presents an M-op
- in_ready  out  1  unit can accept (IDLE only)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  operand A
- rs2  in  32  operand B
- kill  in  1  flush (branch mispredict/trap); aborts in-flight op
- out_valid  out  1  result valid
- out_ready  in  1  writeback consumes result
- result  out  32  final value, held stable while out_valid && !out_ready

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1. On in_valid && !kill: latch op and operands, compute magnitudes and sign flags, go to BUSY with counter=32.
- Fast paths (IDLE -> DONE directly, one cycle after accept):
  - Divide by zero (rs2==0): DIV/DIVU result=32'hFFFFFFFF; REM/REMU result=rs1.
  - Signed overflow (DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF): DIV=32'h80000000, REM=0.
- BUSY, one iteration per cycle, counter decrements; BUSY->DONE when counter reaches 1.
  - Multiply: if multiplier LSB, acc += multiplicand; shift {acc, multiplier} right by 1.
  - Divide: shift remainder left with the next dividend bit; if rem >= divisor, subtract and set the quotient bit.
  - Normal latency: accept edge + 32 BUSY cycles; out_valid asserts on the 33rd edge after acceptance.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Unsigned magnitudes are iterated. The 64-bit product is two's-complement negated when the signs differ.
  - Quotient is negated when the signs differ. Remainder takes the sign of the dividend.
- Result selection: MUL = product[31:0]; MULH* = product[63:32]; DIV* = quotient; REM* = remainder. Result is registered on entry to DONE.
- DONE:
  - out_valid=1, in_ready=0; hold result until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle.
  - There is no accept in the same cycle as completion; back-to-back ops are separated by one IDLE cycle.
- kill:
  - In any state, kill=1 at a clock edge forces IDLE and out_valid=0 next cycle; the partial result is discarded.
  - kill wins over in_valid and over the out handshake in the same cycle.
  - kill in IDLE blocks acceptance.
- rst has priority over kill and all other inputs, including mid-BUSY.
- Operand inputs are sampled only at accept; changes during BUSY/DONE are ignored.
- out_valid never asserts without a preceding accepted in_valid since the last rst/kill.

Decomposition:
- Shared defines header:
  - MD_OP_* funct3 constants (8 codes).
  - MD_STATE_IDLE/BUSY/DONE 2-bit encodings.
  - Opcode/funct7 (7'b0000001) constant used by the decoder to steer R-type ops to this unit instead of the ALU.
- One sub-module is natural: muldiv_signfix (combinational). It takes the op, sign flags and raw 64-bit product/quotient/remainder, and produces the signed-corrected 32-bit result. The FSM, counter and iterative datapath stay in muldiv_unit.

Test Plan:
- MUL: rs1=7, rs2=-3 (32'hFFFFFFFD) -> out_valid 33 cycles after accept, result=32'hFFFFFFEB; MULH same operands -> 32'hFFFFFFFF; MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE.
- DIV/REM: rs1=-7, rs2=2 -> DIV=32'hFFFFFFFD (-3), REM=32'hFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
- Divide by zero: DIVU rs1=5, rs2=0 -> result 32'hFFFFFFFF one cycle after accept; REM rs1=5, rs2=0 -> 5. Overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000 one cycle after accept, REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
- Kill mid-BUSY at iteration 10 -> IDLE next cycle, out_valid never asserts; the following MULHSU rs1=-2, rs2=32'hFFFFFFFF completes with result=32'hFFFFFFFE.
- Reset asserted mid-BUSY and in DONE -> out_valid=0, result=0, in_ready=1 on the next edge; simultaneous kill+in_valid in IDLE -> not accepted.
